// File: rtl/mem_traffic_pkg.sv
// Shared types and constants for the memory traffic initiator.
package mem_traffic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    DRAIN,
    DONE
  } state_t;

  localparam int TAG_TS_W = 16;

  typedef struct packed {
    logic [TAG_TS_W-1:0] ts;
    logic [15:0]         size;
  } tag_t;

  localparam logic [31:0] TOTAL_LAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mti_tag_fifo.sv
// In-order tag FIFO holding {timestamp, size} of outstanding requests.
module mti_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  // A full FIFO still accepts a push when a pop frees the slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_traffic_initiator.sv
// Programmed request generator with in-order response matching
// and latency statistics.
import mem_traffic_pkg::*;

module mem_traffic_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TS_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [15:0]     cfg_num_reqs,
  input  logic [7:0]      cfg_dram_every,
  input  logic [15:0]     cfg_size_bytes,
  input  logic [7:0]      cfg_gap_cycles,
  output logic            req_valid,
  output logic            req_is_dram,
  output logic [15:0]     req_size_bytes,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [15:0]     resp_size_bytes,
  output logic            busy,
  output logic            done,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     resp_cnt,
  output logic [31:0]     total_latency,
  output logic [TS_W-1:0] max_latency,
  output logic            err_unexpected_resp,
  output logic            err_size_mismatch
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int DW = TS_W + 16;

  state_t            state;
  logic [15:0]       num_q;
  logic [7:0]        every_q;
  logic [7:0]        gap_q;
  logic [7:0]        dcnt;
  logic [7:0]        dcnt_nx;
  logic [7:0]        gap_cnt;
  logic [TS_W-1:0]   ts;
  logic              push;
  logic              pop;
  logic [DW-1:0]     rdata;
  logic [TS_W-1:0]   r_ts;
  logic [15:0]       r_size;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occ_next;
  logic              room;
  logic [15:0]       resp_next;
  logic [TS_W-1:0]   lat;
  logic [32:0]       sum;

  assign push      = req_valid && req_ready && (!full || pop);
  assign pop       = resp_valid && !empty;
  assign {r_ts, r_size} = rdata;
  assign occ_next  = count + CW'(push) - CW'(pop);
  assign room      = occ_next < CW'(MAX_OUTSTANDING);
  assign resp_next = resp_cnt + 16'(pop);
  assign lat       = ts - r_ts;
  assign sum       = {1'b0, total_latency} + 33'(lat);
  // DRAM selection reloads instead of dividing by cfg_dram_every.
  assign dcnt_nx   = (dcnt == 8'd1) ? every_q : dcnt - 8'd1;

  mti_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({ts, req_size_bytes}),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      num_q               <= '0;
      every_q             <= '0;
      gap_q               <= '0;
      dcnt                <= '0;
      gap_cnt             <= '0;
      ts                  <= '0;
      req_valid           <= 1'b0;
      req_is_dram         <= 1'b0;
      req_size_bytes      <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      issued_cnt          <= '0;
      resp_cnt            <= '0;
      total_latency       <= '0;
      max_latency         <= '0;
      err_unexpected_resp <= 1'b0;
      err_size_mismatch   <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (pop) begin
        resp_cnt      <= resp_next;
        total_latency <= sum[32] ? TOTAL_LAT_MAX : sum[31:0];
        if (lat > max_latency) max_latency <= lat;
        if (r_size != resp_size_bytes) err_size_mismatch <= 1'b1;
      end
      if (resp_valid && empty) err_unexpected_resp <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q               <= cfg_num_reqs;
            every_q             <= cfg_dram_every;
            gap_q               <= cfg_gap_cycles;
            dcnt                <= cfg_dram_every;
            req_size_bytes      <= cfg_size_bytes;
            req_is_dram         <= cfg_dram_every == 8'd1;
            issued_cnt          <= '0;
            resp_cnt            <= '0;
            total_latency       <= '0;
            max_latency         <= '0;
            err_unexpected_resp <= 1'b0;
            err_size_mismatch   <= 1'b0;
            if (cfg_num_reqs == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              busy      <= 1'b1;
              done      <= 1'b0;
              req_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (push) begin
            issued_cnt  <= issued_cnt + 16'd1;
            dcnt        <= dcnt_nx;
            req_is_dram <= (every_q != 8'd0) && (dcnt_nx == 8'd1);
            if (issued_cnt + 16'd1 == num_q) begin
              state     <= DRAIN;
              req_valid <= 1'b0;
            end else if (gap_q != 8'd0) begin
              state     <= GAP;
              gap_cnt   <= gap_q;
              req_valid <= 1'b0;
            end else begin
              req_valid <= room;
            end
          end else begin
            req_valid <= room;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd1) begin
            state     <= ISSUE;
            req_valid <= room;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DRAIN: begin
          if (occ_next == '0 && resp_next == num_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_traffic_initiator.sv
// Directed bench for mem_traffic_initiator with MAX_OUTSTANDING=2.
module tb_mem_traffic_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] cfg_num_reqs;
  logic [7:0]  cfg_dram_every;
  logic [15:0] cfg_size_bytes;
  logic [7:0]  cfg_gap_cycles;
  logic        req_valid;
  logic        req_is_dram;
  logic [15:0] req_size_bytes;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_size_bytes;
  logic        busy;
  logic        done;
  logic [15:0] issued_cnt;
  logic [15:0] resp_cnt;
  logic [31:0] total_latency;
  logic [15:0] max_latency;
  logic        err_unexpected_resp;
  logic        err_size_mismatch;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int lowcnt;
  logic anyhigh;

  always #5 clk = ~clk;

  mem_traffic_initiator #(
    .MAX_OUTSTANDING (2),
    .TS_W            (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .cfg_num_reqs        (cfg_num_reqs),
    .cfg_dram_every      (cfg_dram_every),
    .cfg_size_bytes      (cfg_size_bytes),
    .cfg_gap_cycles      (cfg_gap_cycles),
    .req_valid           (req_valid),
    .req_is_dram         (req_is_dram),
    .req_size_bytes      (req_size_bytes),
    .req_ready           (req_ready),
    .resp_valid          (resp_valid),
    .resp_size_bytes     (resp_size_bytes),
    .busy                (busy),
    .done                (done),
    .issued_cnt          (issued_cnt),
    .resp_cnt            (resp_cnt),
    .total_latency       (total_latency),
    .max_latency         (max_latency),
    .err_unexpected_resp (err_unexpected_resp),
    .err_size_mismatch   (err_size_mismatch)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] n, input logic [7:0] every,
                     input logic [15:0] size, input logic [7:0] gap);
    cfg_num_reqs   = n;
    cfg_dram_every = every;
    cfg_size_bytes = size;
    cfg_gap_cycles = gap;
  endtask

  task automatic launch();
    start = 1'b1;
    cyc = -1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_size_bytes = '0;
    cfg(16'd0, 8'd0, 16'd0, 8'd0);
    step();
    step();
    chk("reset_ctl", {req_valid, req_is_dram, busy, done,
        err_unexpected_resp, err_size_mismatch}, 64'd0);
    chk("reset_cnt", {issued_cnt, resp_cnt, max_latency}, 64'd0);
    chk("reset_lat", {total_latency, req_size_bytes}, 64'd0);
    reset_n = 1'b1;
    step();

    // response while idle
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    chk("idle_unexp", err_unexpected_resp, 1);
    chk("idle_respcnt", resp_cnt, 0);

    // single SRAM request, latency 2
    cfg(16'd1, 8'd0, 16'd32, 8'd0);
    launch();
    chk("t1_start", {busy, req_valid, req_is_dram, err_unexpected_resp}, 4'b1100);
    chk("t1_size", req_size_bytes, 32);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t1_issue", {issued_cnt, 7'd0, req_valid, busy}, {16'd1, 9'b01});
    step();
    resp_valid = 1'b1;
    resp_size_bytes = 16'd32;
    step();
    resp_valid = 1'b0;
    chk("t1_resp", resp_cnt, 1);
    chk("t1_lat", {total_latency, max_latency}, {32'd2, 16'd2});
    chk("t1_done", {done, busy, err_size_mismatch}, 3'b100);

    // DRAM every 2, back-to-back with latency-1 responses
    cfg(16'd4, 8'd2, 16'd16, 8'd0);
    launch();
    chk("t2_r1", {req_valid, req_is_dram}, 2'b10);
    req_ready = 1'b1;
    step();
    chk("t2_r2", {req_valid, req_is_dram}, 2'b11);
    resp_valid = 1'b1;
    resp_size_bytes = 16'd16;
    step();
    chk("t2_r3", {req_valid, req_is_dram, issued_cnt, resp_cnt},
        {2'b10, 16'd2, 16'd1});
    step();
    chk("t2_r4", {req_valid, req_is_dram, issued_cnt}, {2'b11, 16'd3});
    step();
    req_ready = 1'b0;
    chk("t2_drain", {req_valid, issued_cnt}, {1'b0, 16'd4});
    step();
    resp_valid = 1'b0;
    chk("t2_done", {done, busy, resp_cnt}, {2'b10, 16'd4});
    chk("t2_lat", {total_latency, max_latency}, {32'd4, 16'd1});

    // ready withheld 5 cycles
    cfg(16'd2, 8'd1, 16'd8, 8'd0);
    launch();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", {req_valid, req_is_dram, req_size_bytes, issued_cnt},
          {2'b11, 16'd8, 16'd0});
      step();
    end
    req_ready = 1'b1;
    step();
    chk("t3_x1", {req_valid, req_is_dram, issued_cnt}, {2'b11, 16'd1});
    step();
    req_ready = 1'b0;
    chk("t3_x2", {req_valid, issued_cnt}, {1'b0, 16'd2});
    resp_valid = 1'b1;
    resp_size_bytes = 16'd8;
    step();
    step();
    resp_valid = 1'b0;
    chk("t3_done", {done, total_latency, max_latency},
        {1'b1, 32'd4, 16'd2});

    // gap 3 and outstanding limit of 2 with slow responses
    cfg(16'd3, 8'd0, 16'd32, 8'd3);
    req_ready = 1'b1;
    launch();
    chk("t4_start", req_valid, 1);
    step();
    chk("t4_x1", {req_valid, issued_cnt}, {1'b0, 16'd1});
    lowcnt = 0;
    repeat (3) begin
      if (!req_valid) lowcnt++;
      step();
    end
    chk("t4_gap_low", lowcnt, 3);
    chk("t4_gap_end", req_valid, 1);
    step();
    chk("t4_x2", issued_cnt, 2);
    anyhigh = 1'b0;
    while (cyc < 20) begin
      step();
      anyhigh |= req_valid;
    end
    chk("t4_full_hold", {anyhigh, issued_cnt}, {1'b0, 16'd2});
    resp_valid = 1'b1;
    resp_size_bytes = 16'd32;
    step();
    resp_valid = 1'b0;
    chk("t4_room", {req_valid, resp_cnt, max_latency},
        {1'b1, 16'd1, 16'd20});
    step();
    chk("t4_x3", {req_valid, issued_cnt}, {1'b0, 16'd3});
    while (cyc < 24) step();
    resp_valid = 1'b1;
    step();
    step();
    resp_valid = 1'b0;
    chk("t4_done", {done, busy, resp_cnt}, {2'b10, 16'd3});
    chk("t4_lat", {total_latency, max_latency}, {32'd44, 16'd20});

    // size mismatch
    cfg(16'd1, 8'd0, 16'd32, 8'd0);
    launch();
    step();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_size_bytes = 16'd64;
    step();
    resp_valid = 1'b0;
    chk("t5_mismatch", {err_size_mismatch, err_unexpected_resp, done},
        3'b101);

    // zero-length run
    cfg(16'd0, 8'd0, 16'd32, 8'd0);
    launch();
    chk("t6_zero", {done, busy, req_valid, err_size_mismatch}, 4'b1000);

    // reset mid-DRAIN
    cfg(16'd2, 8'd0, 16'd32, 8'd0);
    req_ready = 1'b1;
    launch();
    step();
    step();
    req_ready = 1'b0;
    chk("t7_drain", {busy, req_valid, issued_cnt}, {2'b10, 16'd2});
    reset_n = 1'b0;
    #2;
    chk("t7_rst_ctl", {busy, done, req_valid, issued_cnt, resp_cnt}, 64'd0);
    chk("t7_rst_sz", req_size_bytes, 0);
    step();
    reset_n = 1'b1;
    cfg(16'd1, 8'd0, 16'd32, 8'd0);
    req_ready = 1'b1;
    launch();
    step();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_size_bytes = 16'd32;
    step();
    resp_valid = 1'b0;
    chk("t7_rerun", {done, busy, err_unexpected_resp, err_size_mismatch,
        issued_cnt, resp_cnt}, {4'b1000, 16'd1, 16'd1});
    chk("t7_lat", {total_latency, max_latency}, {32'd1, 16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
